decoder_nx2n_seq: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with output enable, selectable output polarity and a built-in auto-scan sequencer. In direct mode it decodes an input code with one cycle of latency. In scan mode a single start pulse walks the output through every code 0..2^N-1, holding each for a programmable dwell. It serves as the select/strobe generator for downstream address, chip-select and LED-row logic, and as a self-test pattern source.

---
 rtl/decoder_nx2n_seq_pkg.sv | 23 ++
 rtl/decoder_nx2n_seq_onehot_dec.sv | 19 +
 rtl/decoder_nx2n_seq.sv | 141 ++++++++++++++
 tb/tb_decoder_nx2n_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_nx2n_seq_pkg.sv
// ----------------------------------------------------------------------------
// decoder_nx2n_seq_pkg
// Purpose : shared types and constants for the N-to-2^N sequenced decoder.
//           FSM state encoding, mode constants and a helper that sizes the
//           dwell counter.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package decoder_nx2n_seq_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

  localparam logic ModeDirect = 1'b0;
  localparam logic ModeScan   = 1'b1;

  // Dwell counter width: $clog2(dwell), but never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/decoder_nx2n_seq_onehot_dec.sv
// ----------------------------------------------------------------------------
// onehot_dec
// Purpose : purely combinational N-to-2^N one-hot decoder (active-high).
// Ports   : sel [N-1:0]    code to decode
//           y   [2^N-1:0]  one-hot result, bit sel set
// ----------------------------------------------------------------------------
module onehot_dec #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] y
);

  always_comb begin
    y      = '0;
    y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_nx2n_seq.sv
// ----------------------------------------------------------------------------
// decoder_nx2n_seq
// Purpose : registered N-to-2^N one-hot decoder with output enable, output
//           polarity select and an auto-scan sequencer that walks every code
//           0..2^N-1, holding each for DWELL enabled cycles.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           en     output enable; 0 forces z inactive and freezes a scan
//           mode   0 = direct decode of sel, 1 = scan
//           sel    code decoded in direct mode
//           start  scan request (taken only in idle with mode = 1, en = 1)
//           z      registered decoded output (inverted when ACTIVE_LOW)
//           code   code currently driving z
//           busy   high while a scan is in progress
//           done   one-cycle pulse on normal scan completion
// ----------------------------------------------------------------------------
module decoder_nx2n_seq
  import decoder_nx2n_seq_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DWELL      = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic              start,
  output logic [(1<<N)-1:0] z,
  output logic [N-1:0]      code,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W    = 1 << N;
  localparam int unsigned CntW = cnt_width(DWELL);

  localparam logic [CntW-1:0] CntLast  = CntW'(DWELL - 1);
  localparam logic [N-1:0]    CodeLast = {N{1'b1}};
  // XOR mask: all ones inverts the active-high pattern for active-low output.
  localparam logic [W-1:0]    Inactive = {W{ACTIVE_LOW}};

  state_e          r_state, w_state_next;
  logic [N-1:0]    r_code, w_code_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            w_active_next;
  logic            w_busy_next;
  logic            w_done_next;
  logic [W-1:0]    w_onehot;
  logic [W-1:0]    r_z;
  logic            r_busy;
  logic            r_done;

  // Single decoder on the next code so z and code always update together.
  onehot_dec #(
    .N(N)
  ) u_onehot_dec (
    .sel(w_code_next),
    .y  (w_onehot)
  );

  always_comb begin
    w_state_next  = r_state;
    w_code_next   = r_code;
    w_cnt_next    = r_cnt;
    w_active_next = 1'b0;
    w_busy_next   = 1'b0;
    w_done_next   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (mode == ModeDirect) begin
          w_code_next   = sel;
          w_active_next = en;
        end else if (start && en) begin
          w_state_next  = StScan;
          w_code_next   = '0;
          w_cnt_next    = '0;
          w_active_next = 1'b1;
          w_busy_next   = 1'b1;
        end
      end

      StScan: begin
        if (mode == ModeDirect) begin
          // Abort: drop straight back into direct decoding, no done pulse.
          w_state_next  = StIdle;
          w_code_next   = sel;
          w_cnt_next    = '0;
          w_active_next = en;
        end else if (!en) begin
          // Frozen: counter and code hold, output forced inactive.
          w_busy_next = 1'b1;
        end else if (r_cnt == CntLast) begin
          w_cnt_next = '0;
          if (r_code == CodeLast) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
          end else begin
            w_code_next   = r_code + N'(1);
            w_active_next = 1'b1;
            w_busy_next   = 1'b1;
          end
        end else begin
          w_cnt_next    = r_cnt + CntW'(1);
          w_active_next = 1'b1;
          w_busy_next   = 1'b1;
        end
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_code  <= '0;
      r_cnt   <= '0;
      r_z     <= Inactive;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_code  <= w_code_next;
      r_cnt   <= w_cnt_next;
      r_z     <= w_active_next ? (w_onehot ^ Inactive) : Inactive;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign z    = r_z;
  assign code = r_code;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_decoder_nx2n_seq.sv
// ----------------------------------------------------------------------------
// tb_decoder_nx2n_seq
// Three instances share one stimulus stream:
//   dut 0 : N=2 DWELL=3 active-high
//   dut 1 : N=2 DWELL=3 active-low
//   dut 2 : N=4 DWELL=1 active-high
// The reference model tracks a scan as a count of enabled cycles since start;
// the expected code is that count divided by DWELL.
// ----------------------------------------------------------------------------
module tb_decoder_nx2n_seq;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [3:0]  sel;
  logic        start;

  logic [3:0]  z0, z1;
  logic [15:0] z2;
  logic [1:0]  code0, code1;
  logic [3:0]  code2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_nx2n_seq #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .start(start),
    .z(z0), .code(code0), .busy(busy0), .done(done0)
  );

  decoder_nx2n_seq #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel[1:0]), .start(start),
    .z(z1), .code(code1), .busy(busy1), .done(done1)
  );

  decoder_nx2n_seq #(.N(4), .DWELL(1), .ACTIVE_LOW(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .z(z2), .code(code2), .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  int m_n  [3] = '{2, 2, 4};
  int m_dw [3] = '{3, 3, 1};
  bit m_al [3] = '{1'b0, 1'b1, 1'b0};
  int m_pos [3];
  int m_code[3];
  bit m_busy[3];
  bit m_on  [3];
  bit m_done[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pos[k] = 0; m_code[k] = 0; m_busy[k] = 0; m_on[k] = 0; m_done[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int s;
      int total;
      s     = int'(sel) & ((1 << m_n[k]) - 1);
      total = (1 << m_n[k]) * m_dw[k];
      m_done[k] = 0;
      if (!m_busy[k]) begin
        if (!mode) begin
          m_code[k] = s;
          m_on[k]   = en;
        end else begin
          m_on[k] = 0;
          if (start && en) begin
            m_busy[k] = 1; m_pos[k] = 0; m_code[k] = 0; m_on[k] = 1;
          end
        end
      end else if (!mode) begin
        m_busy[k] = 0; m_code[k] = s; m_on[k] = en;
      end else if (!en) begin
        m_on[k] = 0;
      end else begin
        m_pos[k]++;
        if (m_pos[k] == total) begin
          m_busy[k] = 0; m_on[k] = 0; m_done[k] = 1;
        end else begin
          m_code[k] = m_pos[k] / m_dw[k];
          m_on[k]   = 1;
        end
      end
    end
  endtask

  function automatic logic [15:0] exp_z(int k);
    logic [15:0] v;
    v = m_on[k] ? 16'(1 << m_code[k]) : 16'h0000;
    if (m_al[k]) v = ~v & 16'((1 << (1 << m_n[k])) - 1);
    return v;
  endfunction

  function automatic logic [15:0] obs_z(int k);
    case (k)
      0:       return {12'h000, z0};
      1:       return {12'h000, z1};
      default: return z2;
    endcase
  endfunction

  function automatic logic [3:0] obs_code(int k);
    case (k)
      0:       return {2'b00, code0};
      1:       return {2'b00, code1};
      default: return code2;
    endcase
  endfunction

  function automatic logic [1:0] obs_bd(int k);
    case (k)
      0:       return {busy0, done0};
      1:       return {busy1, done1};
      default: return {busy2, done2};
    endcase
  endfunction

  function automatic logic [1:0] exp_bd(int k);
    return {m_busy[k], m_done[k]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
        n_fail++;
        $display("FAIL reset_initial dut%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                 k, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
      end
    end
    rst_n = 1'b1;
    mode = 1'b1; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    // Reset mid-scan, away from any clock edge; outputs must clear at once.
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
        n_fail++;
        $display("FAIL reset_async dut%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                 k, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_direct();
    mode = 1'b0; start = 1'b0;
    for (int c = 0; c < 28; c++) begin
      sel = (c < 4) ? 4'(c) : 4'($urandom_range(0, 15));
      en  = (c < 4) ? 1'b1 : (c < 8) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
          n_fail++;
          $display("FAIL direct dut%0d cyc%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                   k, c, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
        end
      end
    end
  endtask

  task automatic test_full_scan();
    int d0 = -1;
    int d2 = -1;
    mode = 1'b1; en = 1'b1; start = 1'b1; sel = 4'($urandom_range(0, 15));
    step();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      sel = 4'($urandom_range(0, 15));
      step();
      if (done0 === 1'b1 && d0 < 0) d0 = c;
      if (done2 === 1'b1 && d2 < 0) d2 = c;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
          n_fail++;
          $display("FAIL full_scan dut%0d cyc%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                   k, c, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
        end
      end
    end
    n_checks++;
    if (d0 !== 12) begin
      n_fail++;
      $display("FAIL full_scan_done_n2: done after %0d cycles, required 12", d0);
    end
    n_checks++;
    if (d2 !== 16) begin
      n_fail++;
      $display("FAIL full_scan_done_n4: done after %0d cycles, required 16", d2);
    end
  endtask

  task automatic test_freeze();
    int d0 = -1;
    mode = 1'b1; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      en = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      step();
      if (done0 === 1'b1 && d0 < 0) d0 = c;
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
          n_fail++;
          $display("FAIL freeze dut%0d cyc%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                   k, c, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
        end
      end
    end
    n_checks++;
    if (d0 !== 17) begin
      n_fail++;
      $display("FAIL freeze_done_late: done after %0d cycles, required 17", d0);
    end
  endtask

  task automatic test_abort_and_restart();
    mode = 1'b1; en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 2 || c == 5) ? 1'b1 : 1'b0;  // ignored while busy
      if (c == 7) begin
        mode = 1'b0;  // dut0 sits at code 2 here
        sel  = 4'($urandom_range(0, 15));
      end
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
          n_fail++;
          $display("FAIL abort dut%0d cyc%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                   k, c, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en    = ($urandom_range(0, 7) != 0);
      mode  = ($urandom_range(0, 9) != 0);
      start = ($urandom_range(0, 3) == 0);
      sel   = 4'($urandom_range(0, 15));
      step();
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (obs_z(k) !== exp_z(k) || obs_code(k) !== 4'(m_code[k]) || obs_bd(k) !== exp_bd(k)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: z=%h code=%h busy/done=%b, required z=%h code=%h busy/done=%b",
                   k, c, obs_z(k), obs_code(k), obs_bd(k), exp_z(k), 4'(m_code[k]), exp_bd(k));
        end
      end
    end
    mode = 1'b0; start = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; start = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    test_reset();
    test_direct();
    test_full_scan();
    test_freeze();
    test_abort_and_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
